// File: rtl/memflush_seq_pkg.sv
// memflush_seq_pkg: request codes, TLB flush types, sequencer states and decode helpers.
//   ASID_W / VPN_W : default operand widths (SV39)
//   sfence_flush   : SFENCE.VMA operand pattern -> TLB flush type
//   first_state    : first sequence state for an accepted request
package memflush_seq_pkg;
  localparam int ASID_W = 16;
  localparam int VPN_W = 27;
  typedef enum logic [2:0] {
    MF_FENCE_I    = 3'd0,
    MF_SFENCE_VMA = 3'd1,
    MF_EXCEPT_I   = 3'd2,
    MF_EXCEPT_D   = 3'd3,
    MF_ECALL      = 3'd4
  } mf_req_t;
  typedef enum logic [1:0] {
    NoFlush   = 2'd0,
    FlushAll  = 2'd1,
    FlushASID = 2'd2,
    FlushPage = 2'd3
  } tlb_flush_e;
  typedef enum logic [2:0] {
    MF_IDLE = 3'd0,
    MF_CLR  = 3'd1,
    MF_SYNC = 3'd2,
    MF_TLBF = 3'd3,
    MF_DONE = 3'd4
  } mf_state_e;
  function automatic tlb_flush_e sfence_flush(input logic rs1_zero, input logic rs2_zero);
    return !rs1_zero ? FlushPage : rs2_zero ? FlushAll : FlushASID;
  endfunction
  // FENCE.I and ECALL write back first; SFENCE and exceptions clear first; unknown codes finish at once.
  function automatic mf_state_e first_state(input mf_req_t t);
    return (t == MF_FENCE_I || t == MF_ECALL) ? MF_SYNC :
           (t == MF_SFENCE_VMA || t == MF_EXCEPT_I || t == MF_EXCEPT_D) ? MF_CLR : MF_DONE;
  endfunction
endpackage

// File: rtl/memflush_seq_timeout.sv
// sat_timeout_cnt: saturating wait counter that flags expiry after LIMIT cycles of enable.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : synchronous clear to zero (priority over enable)
//   en_i           : count enable
//   expire_o       : counter sits at LIMIT-1
module sat_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_cnt <= '0;
    else if (clr_i) r_cnt <= '0;
    else if (en_i && !expire_o) r_cnt <= r_cnt + 1'b1;
  end
  assign expire_o = r_cnt == LAST;
endmodule

// File: rtl/memflush_seq.sv
// memflush_seq: expands CU maintenance requests into MSHR clears, L1D->L2 sync and TLB flush.
//   clk_i, rst_n_i              : clock, async active-low reset
//   req_valid_i/req_ready_o     : request handshake (ready only when idle)
//   req_type_i, req_rs*_zero_i  : request code and SFENCE.VMA operand pattern
//   req_asid_i, req_vpn_i       : flush operands, captured on accept
//   stall_o, done_o, timeout_o  : busy, completion pulse, sticky sync timeout
//   clr_*/clear_dmshr_dregs_o   : one-cycle clear pulses
//   synch_l1dc_l2c_o            : write-back request level, l2c_update_done_i ends it
//   L1TLB/L2TLB_flush_type_o    : flush type, live only in the TLB flush cycle
//   flush_asid_o, flush_page_o  : captured flush operands
module memflush_seq
  import memflush_seq_pkg::*;
#(
  parameter int ASID_LEN = ASID_W,
  parameter int VPN_LEN = VPN_W,
  parameter int SYNC_TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [2:0]          req_type_i,
  input  logic                req_rs1_zero_i,
  input  logic                req_rs2_zero_i,
  input  logic [ASID_LEN-1:0] req_asid_i,
  input  logic [VPN_LEN-1:0]  req_vpn_i,
  output logic                stall_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                clr_l1tlb_mshr_o,
  output logic                clr_l2tlb_mshr_o,
  output logic                clear_dmshr_dregs_o,
  output logic                synch_l1dc_l2c_o,
  input  logic                l2c_update_done_i,
  output logic [1:0]          L1TLB_flush_type_o,
  output logic [1:0]          L2TLB_flush_type_o,
  output logic [ASID_LEN-1:0] flush_asid_o,
  output logic [VPN_LEN-1:0]  flush_page_o
);
  mf_state_e r_state, w_next;
  mf_req_t r_type;
  tlb_flush_e r_flush;
  logic [ASID_LEN-1:0] r_asid;
  logic [VPN_LEN-1:0] r_vpn;
  logic r_timeout;
  logic w_accept, w_expire;
  mf_req_t w_req_type;
  assign w_req_type = mf_req_t'(req_type_i);
  assign w_accept = req_valid_i && r_state == MF_IDLE;
  sat_timeout_cnt #(.LIMIT(SYNC_TIMEOUT)) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (r_state != MF_SYNC),
    .en_i    (r_state == MF_SYNC),
    .expire_o(w_expire)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= MF_IDLE;
    else r_state <= w_next;
  end
  // After SYNC: FENCE.I clears the TLB MSHRs, SFENCE flushes the TLBs, ECALL is finished.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MF_IDLE: w_next = req_valid_i ? first_state(w_req_type) : MF_IDLE;
      MF_CLR:  w_next = r_type == MF_SFENCE_VMA ? MF_SYNC : MF_DONE;
      MF_SYNC: w_next = l2c_update_done_i ? (r_type == MF_FENCE_I ? MF_CLR :
                                             r_type == MF_SFENCE_VMA ? MF_TLBF : MF_DONE) :
                        w_expire ? MF_DONE : MF_SYNC;
      MF_TLBF: w_next = MF_DONE;
      default: w_next = MF_IDLE;
    endcase
  end
  always_comb begin
    req_ready_o = r_state == MF_IDLE;
    stall_o = r_state != MF_IDLE;
    done_o = r_state == MF_DONE;
    clr_l1tlb_mshr_o = r_state == MF_CLR && r_type != MF_EXCEPT_D;
    clr_l2tlb_mshr_o = r_state == MF_CLR && r_type != MF_EXCEPT_D;
    clear_dmshr_dregs_o = r_state == MF_CLR && (r_type == MF_SFENCE_VMA || r_type == MF_EXCEPT_D);
    synch_l1dc_l2c_o = r_state == MF_SYNC;
    L1TLB_flush_type_o = r_state == MF_TLBF ? r_flush : NoFlush;
    L2TLB_flush_type_o = r_state == MF_TLBF ? r_flush : NoFlush;
    flush_asid_o = r_asid;
    flush_page_o = r_vpn;
    timeout_o = r_timeout;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_type <= MF_FENCE_I;
      r_flush <= NoFlush;
      r_asid <= '0;
      r_vpn <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type <= w_req_type;
        r_flush <= sfence_flush(req_rs1_zero_i, req_rs2_zero_i);
        r_asid <= req_asid_i;
        r_vpn <= req_vpn_i;
      end
      r_timeout <= w_accept ? 1'b0 :
                   (r_state == MF_SYNC && !l2c_update_done_i && w_expire) ? 1'b1 : r_timeout;
    end
  end
endmodule

// File: tb/tb_memflush_seq.sv
// tb_memflush_seq: scoreboard bench; expectations queued at issue, checked by a monitor on done_o.
module tb_memflush_seq;
  import memflush_seq_pkg::*;
  localparam int TO = 8;
  logic clk_i = 0, rst_n_i = 0, req_valid_i = 0, req_rs1_zero_i = 0, req_rs2_zero_i = 0;
  logic [2:0] req_type_i = 0;
  logic [15:0] req_asid_i = 0;
  logic [26:0] req_vpn_i = 0;
  logic l2c_update_done_i = 0;
  logic req_ready_o, stall_o, done_o, timeout_o, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o;
  logic clear_dmshr_dregs_o, synch_l1dc_l2c_o;
  logic [1:0] L1TLB_flush_type_o, L2TLB_flush_type_o;
  logic [15:0] flush_asid_o;
  logic [26:0] flush_page_o;

  memflush_seq #(.ASID_LEN(16), .VPN_LEN(27), .SYNC_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_rs1_zero_i(req_rs1_zero_i), .req_rs2_zero_i(req_rs2_zero_i),
    .req_asid_i(req_asid_i), .req_vpn_i(req_vpn_i), .stall_o(stall_o), .done_o(done_o),
    .timeout_o(timeout_o), .clr_l1tlb_mshr_o(clr_l1tlb_mshr_o), .clr_l2tlb_mshr_o(clr_l2tlb_mshr_o),
    .clear_dmshr_dregs_o(clear_dmshr_dregs_o), .synch_l1dc_l2c_o(synch_l1dc_l2c_o),
    .l2c_update_done_i(l2c_update_done_i), .L1TLB_flush_type_o(L1TLB_flush_type_o),
    .L2TLB_flush_type_o(L2TLB_flush_type_o), .flush_asid_o(flush_asid_o), .flush_page_o(flush_page_o)
  );

  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string nm;
    int lat, clr, clr_cyc, clr_n, sync_n, sync_first, ft, ft_cyc, ft_n, l2x, stall_n, tmo, tmo1;
    int chk_ops, asid, vpn;
  } rec_t;
  rec_t exp_q[$];
  rec_t obs, e;
  int active = 0, acc_cyc = 0, rel = 0;
  int acc_log[$];
  int n_cmp = 0, n_bad = 0;
  int l2_delay = -1, sync_age = -1;
  bit ok;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(string nm, int lat, int clr, int clr_cyc, int sync_n, int sync_first,
                              int ft, int ft_cyc, int tmo);
    rec_t r;
    r = '{default: 0};
    r.nm = nm; r.lat = lat; r.clr = clr; r.clr_cyc = clr_cyc; r.clr_n = clr != 0 ? 1 : 0;
    r.sync_n = sync_n; r.sync_first = sync_first; r.ft = ft; r.ft_cyc = ft_cyc;
    r.ft_n = ft != 0 ? 1 : 0; r.stall_n = lat; r.tmo = tmo;
    return r;
  endfunction

  // L2 model: raises update-done l2_delay cycles after the sync request appears (never if < 0).
  initial forever begin
    @(posedge clk_i);
    #1;
    sync_age = synch_l1dc_l2c_o ? sync_age + 1 : -1;
    l2c_update_done_i = synch_l1dc_l2c_o && l2_delay >= 0 && sync_age == l2_delay;
  end

  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i) active = 0;
    else begin
      if (active) begin
        rel = cyc - acc_cyc;
        if (clr_l1tlb_mshr_o || clr_l2tlb_mshr_o || clear_dmshr_dregs_o) begin
          obs.clr = obs.clr | int'({clr_l1tlb_mshr_o, clr_l2tlb_mshr_o, clear_dmshr_dregs_o});
          obs.clr_cyc = rel;
          obs.clr_n++;
        end
        if (synch_l1dc_l2c_o) begin
          if (obs.sync_first < 0) obs.sync_first = rel;
          obs.sync_n++;
        end
        if (L1TLB_flush_type_o != 2'd0) begin
          obs.ft = int'(L1TLB_flush_type_o); obs.ft_cyc = rel; obs.ft_n++;
          obs.asid = int'(flush_asid_o); obs.vpn = int'(flush_page_o);
        end
        if (L1TLB_flush_type_o != L2TLB_flush_type_o) obs.l2x++;
        if (stall_o) obs.stall_n++;
        if (rel == 1) obs.tmo1 = int'(timeout_o);
        if (done_o || rel > 60) begin
          active = 0;
          obs.lat = done_o ? rel : -1;
          obs.tmo = int'(timeout_o);
          if (exp_q.size() == 0) chk("unexpected_done", cyc, -1);
          else begin
            e = exp_q.pop_front();
            chk({e.nm, ".latency"}, obs.lat, e.lat);
            chk({e.nm, ".clear_set"}, obs.clr, e.clr);
            chk({e.nm, ".clear_cycle"}, obs.clr_cyc, e.clr_cyc);
            chk({e.nm, ".clear_pulses"}, obs.clr_n, e.clr_n);
            chk({e.nm, ".sync_cycles"}, obs.sync_n, e.sync_n);
            chk({e.nm, ".sync_first"}, obs.sync_first, e.sync_first);
            chk({e.nm, ".flush_type"}, obs.ft, e.ft);
            chk({e.nm, ".flush_cycle"}, obs.ft_cyc, e.ft_cyc);
            chk({e.nm, ".flush_cycles"}, obs.ft_n, e.ft_n);
            chk({e.nm, ".l1_l2_flush_differ"}, obs.l2x, 0);
            chk({e.nm, ".stall_cycles"}, obs.stall_n, e.stall_n);
            chk({e.nm, ".timeout_at_done"}, obs.tmo, e.tmo);
            chk({e.nm, ".timeout_after_accept"}, obs.tmo1, e.tmo1);
            if (e.chk_ops != 0) begin
              chk({e.nm, ".flush_asid"}, obs.asid, e.asid);
              chk({e.nm, ".flush_page"}, obs.vpn, e.vpn);
            end
          end
        end
      end else if (done_o) chk("unexpected_done_idle", cyc, -1);
      if (req_valid_i && req_ready_o) begin
        active = 1;
        acc_cyc = cyc;
        acc_log.push_back(cyc);
        obs = '{default: 0};
        obs.clr_cyc = -1; obs.sync_first = -1; obs.ft_cyc = -1;
      end
    end
  end

  task automatic wait_accept();
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (req_ready_o) ok = 1;
    end
    @(posedge clk_i);
    #1;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic issue(int t, bit rs1z, bit rs2z, int asid, int vpn, bit hold);
    req_type_i = t[2:0]; req_rs1_zero_i = rs1z; req_rs2_zero_i = rs2z;
    req_asid_i = asid[15:0]; req_vpn_i = vpn[26:0]; req_valid_i = 1;
    wait_accept();
    if (!hold) req_valid_i = 0;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0 && !active) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    rec_t r;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1;
    #1;
    chk("rst.ready", req_ready_o, 1);
    chk("rst.stall", stall_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.timeout", timeout_o, 0);
    chk("rst.clears", {clr_l1tlb_mshr_o, clr_l2tlb_mshr_o, clear_dmshr_dregs_o}, 0);
    chk("rst.sync", synch_l1dc_l2c_o, 0);
    chk("rst.l1_flush", L1TLB_flush_type_o, 0);
    chk("rst.l2_flush", L2TLB_flush_type_o, 0);
    chk("rst.asid", flush_asid_o, 0);
    chk("rst.page", flush_page_o, 0);
    @(posedge clk_i);
    #1;
    exp_q.push_back(mk("except_d", 2, 3'b001, 1, 0, -1, 0, -1, 0));
    issue(3, 1, 1, 0, 0, 0);
    wait_quiet();
    l2_delay = 3;
    r = mk("sfence_page", 7, 3'b111, 1, 4, 2, 3, 6, 0);
    r.chk_ops = 1; r.asid = 5; r.vpn = 'h1234;
    exp_q.push_back(r);
    issue(1, 0, 0, 5, 'h1234, 0);
    wait_quiet();
    l2_delay = 0;
    exp_q.push_back(mk("sfence_all", 4, 3'b111, 1, 1, 2, 1, 3, 0));
    issue(1, 1, 1, 7, 0, 0);
    wait_quiet();
    l2_delay = 1;
    r = mk("sfence_asid", 5, 3'b111, 1, 2, 2, 2, 4, 0);
    r.chk_ops = 1; r.asid = 'h3A; r.vpn = 'h55;
    exp_q.push_back(r);
    issue(1, 1, 0, 'h3A, 'h55, 0);
    wait_quiet();
    exp_q.push_back(mk("except_i", 2, 3'b110, 1, 0, -1, 0, -1, 0));
    issue(2, 1, 1, 0, 0, 0);
    wait_quiet();
    exp_q.push_back(mk("unknown", 1, 0, -1, 0, -1, 0, -1, 0));
    issue(6, 1, 1, 0, 0, 0);
    wait_quiet();
    l2_delay = -1;
    exp_q.push_back(mk("ecall_timeout", 9, 0, -1, TO, 1, 0, -1, 1));
    issue(4, 1, 1, 0, 0, 0);
    wait_quiet();
    chk("timeout_sticky", timeout_o, 1);
    l2_delay = 2;
    exp_q.push_back(mk("ecall", 4, 0, -1, 3, 1, 0, -1, 0));
    issue(4, 1, 1, 0, 0, 0);
    wait_quiet();
    exp_q.push_back(mk("fence_i", 5, 3'b110, 4, 3, 1, 0, -1, 0));
    exp_q.push_back(mk("held_except_d", 2, 3'b001, 1, 0, -1, 0, -1, 0));
    issue(0, 1, 1, 0, 0, 1);
    chk("busy_not_ready", req_ready_o, 0);
    req_type_i = 3'd3;
    wait_accept();
    req_valid_i = 0;
    chk("held_accept_gap", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 6);
    wait_quiet();
    l2_delay = -1;
    issue(4, 1, 1, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("mid_reset.sync_before", synch_l1dc_l2c_o, 1);
    rst_n_i = 0;
    #1;
    chk("mid_reset.sync", synch_l1dc_l2c_o, 0);
    chk("mid_reset.stall", stall_o, 0);
    chk("mid_reset.ready", req_ready_o, 1);
    chk("mid_reset.done", done_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1;
    repeat (15) @(posedge clk_i);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule

// File: doc/memflush_seq.md
# memflush_seq

Memory-flush sequencer sitting directly downstream of the main control-unit FSM. It accepts one maintenance request at a time: FENCE.I, SFENCE.VMA, an instruction-side exception, a data-side exception or an environment call. It expands each request into an ordered sequence of MSHR clears, an L1D→L2 synchronisation and a TLB flush, driving the memory subsystem's control inputs. It holds the pipeline stalled until the sequence completes.

## Interface
- Parameters:
- `ASID_LEN`, 16: width of the address-space ID.
- `VPN_LEN`, 27: virtual page number width (SV39).
- `SYNC_TIMEOUT`, 1024: maximum cycles spent waiting for `l2c_update_done_i`; must be ≥ 2.
- Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`, in, 1: clock.
- `rst_n_i`, in, 1: asynchronous active-low reset.
- `req_valid_i`, in, 1: request valid from the CU.
- `req_ready_o`, out, 1: sequencer idle and able to accept.
- `req_type_i`, in, 3: `mf_req_t` request code.
- `req_rs1_zero_i`, in, 1: SFENCE.VMA rs1 == x0.
- `req_rs2_zero_i`, in, 1: SFENCE.VMA rs2 == x0.
- `req_asid_i`, in, ASID_LEN: ASID operand.
- `req_vpn_i`, in, VPN_LEN: page operand.
- `stall_o`, out, 1: pipeline stall; high while busy.
- `done_o`, out, 1: one-cycle completion pulse.
- `timeout_o`, out, 1: last sync timed out; sticky until the next accept.
- `clr_l1tlb_mshr_o`, out, 1: clear L1 TLB MSHR; one-cycle pulse.
- `clr_l2tlb_mshr_o`, out, 1: clear L2 TLB MSHR; one-cycle pulse.
- `clear_dmshr_dregs_o`, out, 1: clear D$ MSHR and registers; one-cycle pulse.
- `synch_l1dc_l2c_o`, out, 1: L1D→L2 write-back request, level.
- `l2c_update_done_i`, in, 1: write-back complete.
- `L1TLB_flush_type_o`, out, 2: `tlb_flush_e` for the L1 TLB.
- `L2TLB_flush_type_o`, out, 2: `tlb_flush_e` for the L2 TLB.
- `flush_asid_o`, out, ASID_LEN: ASID for the flush.
- `flush_page_o`, out, VPN_LEN: page for the flush.

## Operation
- States:
- IDLE
- CLR: pulse clears.
- SYNC: wait for L2.
- TLBF: TLB flush.
- DONE
- Accept happens on `req_valid_i & req_ready_o`. `req_ready_o` = (state == IDLE).
- On accept, the type, operands and flush type are registered and `timeout_o` is cleared.
- Sequences, with the CLR pulse set used in each case:
- MF_FENCE_I: SYNC→CLR{l1tlb, l2tlb}→DONE.
- MF_SFENCE_VMA: CLR{l1tlb, l2tlb, dmshr}→SYNC→TLBF→DONE.
- MF_EXCEPT_I: CLR{l1tlb, l2tlb}→DONE.
- MF_EXCEPT_D: CLR{dmshr}→DONE.
- MF_ECALL: SYNC→DONE.
- Any other code: DONE directly, with no side effects.
- SFENCE flush type:
- rs1 = 0 and rs2 = 0: FlushAll.
- rs1 = 0 and rs2 ≠ 0: FlushASID.
- rs1 ≠ 0: FlushPage, using both VPN and ASID.
- Both TLB flush-type outputs carry the same value.
- SYNC state:
- `synch_l1dc_l2c_o` = 1 throughout, including the cycle in which done is sampled.
- A wait counter resets to 0 on entry.
- When `l2c_update_done_i` = 1, the next state is taken.
- If the counter reaches SYNC_TIMEOUT-1 without done: set `timeout_o`, abandon the remaining sequence and go to DONE.
- TLBF: the flush type is driven for exactly one cycle. In every other state both flush types are NoFlush.
- DONE: `done_o` = 1 for one cycle, then IDLE.
- `stall_o` = (state != IDLE).
- `l2c_update_done_i` is ignored outside SYNC.
- A new `req_valid_i` while busy is not accepted; the CU holds it.

## Timing
- All outputs are Moore, decoded from registered state.
- Reset values:
- State IDLE.
- `req_ready_o` = 1.
- `stall_o`, `done_o`, `timeout_o` = 0.
- All clear and sync outputs 0.
- Flush types NoFlush.
- `flush_asid_o` and `flush_page_o` = 0.
- Accept at cycle 0; the first sequence state is at cycle 1.
- Fixed latencies, accept to `done_o`:
- EXCEPT_I and EXCEPT_D: done at cycle 2.
- Unknown type: done at cycle 1.
- SYNC dwell: k+1 cycles when done arrives k cycles after entry. Timeout dwell is SYNC_TIMEOUT cycles.
- `req_ready_o` returns high the cycle after DONE. Back-to-back requests are accepted at DONE+1.
- An asynchronous reset mid-sequence immediately returns all outputs to their reset values. The in-flight request is lost and no `done_o` is produced.

## Structure
- New typedefs go in `memory_pkg`:
- `mf_req_t`: MF_FENCE_I = 0, MF_SFENCE_VMA = 1, MF_EXCEPT_I = 2, MF_EXCEPT_D = 3, MF_ECALL = 4.
- The sequencer state enum.
- `tlb_flush_e` is reused: NoFlush = 0, FlushAll = 1, FlushASID = 2, FlushPage = 3.
- ASID and VPN widths come from `memory_pkg`/`csr_pkg` constants.
- The SYNC wait counter is a natural sub-module, `sat_timeout_cnt`: clear, enable, expire flag, width $clog2(SYNC_TIMEOUT).

## Test plan
- **Reset:** assert `rst_n_i` = 0 for 3 cycles, then release → `req_ready_o` = 1, `stall_o` = 0, all clears = 0, flush types NoFlush.
- **EXCEPT_D:** accept at cycle 0 → `clear_dmshr_dregs_o` = 1 only at cycle 1, `done_o` at cycle 2, `stall_o` high for cycles 1–2.
- **SFENCE, page flush:** rs1 ≠ 0, ASID = 0x5, VPN = 0x1234, `l2c_update_done_i` rises 3 cycles after SYNC entry →
  - all three clears at cycle 1,
  - sync high for cycles 2–5,
  - TLBF at cycle 6 with FlushPage, ASID 5, VPN 0x1234,
  - `done_o` at cycle 7.
- **SFENCE, other flush types:** rs1 = 0 and rs2 = 0 → FlushAll; rs1 = 0, rs2 ≠ 0 → FlushASID in TLBF.
- **Sync timeout:** ECALL with `l2c_update_done_i` tied low, SYNC_TIMEOUT = 8 → sync high for 8 cycles, then `done_o` with `timeout_o` = 1; `timeout_o` clears on the next accept.
- **Busy and reset:**
  - A second request during FENCE_I is held, not accepted, until DONE+1.
  - A reset asserted during SYNC drops sync immediately, with no `done_o`.
